wbsplitter: RTL and testbench

Single-master to dual-slave pipelined Wishbone splitter: the one-to-many counterpart of the bus arbiter. It decodes each strobe's address and forwards the request to slave A or slave B. It tracks outstanding requests and stalls the master whenever a request would switch slaves before the previous slave's acknowledgements have drained. Requests to unmapped addresses receive a locally generated error. It sits between a CPU/arbiter bus and peripheral/memory segments.

---
 rtl/wbsplitter.sv | 152 +++++++++++++++
 tb/tb_wbsplitter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbsplitter.sv
// Single-master to dual-slave pipelined Wishbone splitter with address decode,
// outstanding-request tracking, slave-switch stalling and local decode errors.
module wbsplitter #(
    parameter int              DW     = 32,
    parameter int              AW     = 19,
    parameter logic [AW-1:0]   A_BASE = 19'h00000,
    parameter logic [AW-1:0]   A_MASK = 19'h40000,
    parameter logic [AW-1:0]   B_BASE = 19'h40000,
    parameter logic [AW-1:0]   B_MASK = 19'h60000,
    parameter int              LGOUT  = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    // master side
    input  logic            i_cyc,
    input  logic            i_stb,
    input  logic            i_we,
    input  logic [AW-1:0]   i_adr,
    input  logic [DW-1:0]   i_dat,
    input  logic [DW/8-1:0] i_sel,
    output logic            o_ack,
    output logic            o_stall,
    output logic            o_err,
    output logic [DW-1:0]   o_data,
    // slave A
    output logic            o_a_cyc,
    output logic            o_a_stb,
    output logic            o_a_we,
    output logic [AW-1:0]   o_a_adr,
    output logic [DW-1:0]   o_a_dat,
    output logic [DW/8-1:0] o_a_sel,
    input  logic            i_a_ack,
    input  logic            i_a_stall,
    input  logic            i_a_err,
    input  logic [DW-1:0]   i_a_data,
    // slave B
    output logic            o_b_cyc,
    output logic            o_b_stb,
    output logic            o_b_we,
    output logic [AW-1:0]   o_b_adr,
    output logic [DW-1:0]   o_b_dat,
    output logic [DW/8-1:0] o_b_sel,
    input  logic            i_b_ack,
    input  logic            i_b_stall,
    input  logic            i_b_err,
    input  logic [DW-1:0]   i_b_data
);

    localparam logic [1:0] SlvIdle = 2'd0;
    localparam logic [1:0] SlvA    = 2'd1;
    localparam logic [1:0] SlvB    = 2'd2;

    logic [1:0]       r_slave;
    logic [LGOUT-1:0] r_pend;
    logic             r_derr;
    logic             r_abort;

    logic             dec_a, dec_b, dec_x;
    logic             pend_zero, slv_ack, slv_err, retire, room, can_req;
    logic             acc_a, acc_b, acc_x, issue_a, issue_b, issue;
    logic [LGOUT-1:0] pend_next;

    always_comb begin
        dec_a = ((i_adr & A_MASK) == A_BASE);
        dec_b = !dec_a && ((i_adr & B_MASK) == B_BASE);
        dec_x = !dec_a && !dec_b;

        pend_zero = (r_pend == '0);

        slv_ack = 1'b0;
        slv_err = 1'b0;
        case (r_slave)
            SlvA: begin
                slv_ack = i_a_ack;
                slv_err = i_a_err;
            end
            SlvB: begin
                slv_ack = i_b_ack;
                slv_err = i_b_err;
            end
            default: ;
        endcase

        // Acks with nothing outstanding are ignored, so the counter cannot underflow.
        retire = slv_ack && !pend_zero;
        // A full counter frees a slot in the same cycle an ack retires one.
        room   = !(&r_pend) || retire;

        can_req = !i_rst && i_cyc && i_stb && !r_abort && !r_derr && !slv_err && room;
        acc_a   = can_req && dec_a && (r_slave == SlvA || pend_zero);
        acc_b   = can_req && dec_b && (r_slave == SlvB || pend_zero);
        acc_x   = can_req && dec_x && pend_zero;

        issue_a = acc_a && !i_a_stall;
        issue_b = acc_b && !i_b_stall;
        issue   = issue_a || issue_b;

        pend_next = r_pend;
        if (issue && !retire) begin
            pend_next = r_pend + LGOUT'(1);
        end else if (!issue && retire) begin
            pend_next = r_pend - LGOUT'(1);
        end
    end

    always_comb begin
        o_stall = !(issue || acc_x);
        o_ack   = !i_rst && i_cyc && retire;
        o_err   = !i_rst && i_cyc && (r_derr || slv_err);
        o_data  = (r_slave == SlvB) ? i_b_data : i_a_data;

        o_a_cyc = !i_rst && i_cyc && !r_abort && (r_slave == SlvA || acc_a);
        o_a_stb = acc_a;
        o_a_we  = i_we;
        o_a_adr = i_adr;
        o_a_dat = i_dat;
        o_a_sel = i_sel;

        o_b_cyc = !i_rst && i_cyc && !r_abort && (r_slave == SlvB || acc_b);
        o_b_stb = acc_b;
        o_b_we  = i_we;
        o_b_adr = i_adr;
        o_b_dat = i_dat;
        o_b_sel = i_sel;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_cyc) begin
            r_slave <= SlvIdle;
            r_pend  <= '0;
            r_derr  <= 1'b0;
            r_abort <= 1'b0;
        end else if (r_derr || slv_err) begin
            // Any error kills the rest of the cycle until the master drops i_cyc.
            r_slave <= SlvIdle;
            r_pend  <= '0;
            r_derr  <= 1'b0;
            r_abort <= 1'b1;
        end else begin
            r_pend <= pend_next;
            r_derr <= acc_x;
            if (issue_a) begin
                r_slave <= SlvA;
            end else if (issue_b) begin
                r_slave <= SlvB;
            end else if (pend_next == '0) begin
                r_slave <= SlvIdle;
            end
        end
    end

endmodule

// File: tb/tb_wbsplitter.sv
// Self-checking bench for wbsplitter: decode vector table plus hand-written
// multi-cycle sequences, with a read-data scoreboard on the master ack.
module tb_wbsplitter;

    localparam int DW    = 32;
    localparam int AW    = 19;
    localparam int LGOUT = 2;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_cyc, i_stb, i_we;
    logic [AW-1:0]   i_adr;
    logic [DW-1:0]   i_dat;
    logic [DW/8-1:0] i_sel;
    logic            o_ack, o_stall, o_err;
    logic [DW-1:0]   o_data;
    logic            o_a_cyc, o_a_stb, o_a_we;
    logic [AW-1:0]   o_a_adr;
    logic [DW-1:0]   o_a_dat;
    logic [DW/8-1:0] o_a_sel;
    logic            i_a_ack, i_a_stall, i_a_err;
    logic [DW-1:0]   i_a_data;
    logic            o_b_cyc, o_b_stb, o_b_we;
    logic [AW-1:0]   o_b_adr;
    logic [DW-1:0]   o_b_dat;
    logic [DW/8-1:0] o_b_sel;
    logic            i_b_ack, i_b_stall, i_b_err;
    logic [DW-1:0]   i_b_data;

    wbsplitter #(
        .DW   (DW),
        .AW   (AW),
        .LGOUT(LGOUT)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_cyc    (i_cyc),
        .i_stb    (i_stb),
        .i_we     (i_we),
        .i_adr    (i_adr),
        .i_dat    (i_dat),
        .i_sel    (i_sel),
        .o_ack    (o_ack),
        .o_stall  (o_stall),
        .o_err    (o_err),
        .o_data   (o_data),
        .o_a_cyc  (o_a_cyc),
        .o_a_stb  (o_a_stb),
        .o_a_we   (o_a_we),
        .o_a_adr  (o_a_adr),
        .o_a_dat  (o_a_dat),
        .o_a_sel  (o_a_sel),
        .i_a_ack  (i_a_ack),
        .i_a_stall(i_a_stall),
        .i_a_err  (i_a_err),
        .i_a_data (i_a_data),
        .o_b_cyc  (o_b_cyc),
        .o_b_stb  (o_b_stb),
        .o_b_we   (o_b_we),
        .o_b_adr  (o_b_adr),
        .o_b_dat  (o_b_dat),
        .o_b_sel  (o_b_sel),
        .i_b_ack  (i_b_ack),
        .i_b_stall(i_b_stall),
        .i_b_err  (i_b_err),
        .i_b_data (i_b_data)
    );

    always #5 i_clk = ~i_clk;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mon_exp;

    typedef struct {
        logic [AW-1:0] adr;
        logic          exp_a;
        logic          exp_b;
        logic          exp_stall;
        logic          exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every master ack must match the oldest outstanding expectation.
    always @(negedge i_clk) begin
        if (o_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL ack_unexpected: got ack data %h expected no ack", o_data);
            end else begin
                mon_exp = exp_q.pop_front();
                chk32("ack_data", o_data, mon_exp);
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_cyc     = 1'b0;
        i_stb     = 1'b0;
        i_we      = 1'b0;
        i_adr     = '0;
        i_dat     = '0;
        i_sel     = '0;
        i_a_ack   = 1'b0;
        i_a_stall = 1'b0;
        i_a_err   = 1'b0;
        i_a_data  = '0;
        i_b_ack   = 1'b0;
        i_b_stall = 1'b0;
        i_b_err   = 1'b0;
        i_b_data  = '0;
    endtask

    task automatic drv(input logic we, input logic [AW-1:0] adr);
        i_cyc = 1'b1;
        i_stb = 1'b1;
        i_we  = we;
        i_adr = adr;
        i_dat = {13'h0, adr};
        i_sel = '1;
    endtask

    task automatic drain_chk(input string name);
        chk32(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        vecs[0] = '{19'h00010, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{19'h3FFFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{19'h20000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{19'h40000, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{19'h5FFFF, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{19'h60000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{19'h7FFFF, 1'b0, 1'b0, 1'b0, 1'b1};

        idle();
        i_rst = 1'b1;

        // Reset holds every output quiet even with a live request and stray ack
        tick();
        drv(1'b0, 19'h00000);
        i_a_ack = 1'b1;
        #2;
        chk1("rst_a_cyc", o_a_cyc, 1'b0);
        chk1("rst_a_stb", o_a_stb, 1'b0);
        chk1("rst_stall", o_stall, 1'b1);
        chk1("rst_ack", o_ack, 1'b0);
        chk1("rst_err", o_err, 1'b0);
        tick();
        i_rst = 1'b0;
        idle();

        // Decode table, slaves stalled so mapped requests never issue
        for (int i = 0; i < 7; i++) begin
            tick();
            drv(1'b0, vecs[i].adr);
            i_a_stall = 1'b1;
            i_b_stall = 1'b1;
            #2;
            chk1("vec_a_stb", o_a_stb, vecs[i].exp_a);
            chk1("vec_a_cyc", o_a_cyc, vecs[i].exp_a);
            chk1("vec_b_stb", o_b_stb, vecs[i].exp_b);
            chk1("vec_stall", o_stall, vecs[i].exp_stall);
            tick();
            i_stb = 1'b0;
            #2;
            chk1("vec_err", o_err, vecs[i].exp_err);
            tick();
            idle();
        end

        // Read A, then an immediate switch to B proves the count drained
        tick();
        drv(1'b0, 19'h00010);
        exp_q.push_back(32'hDEADBEEF);
        #2;
        chk1("rd_a_stb", o_a_stb, 1'b1);
        chk1("rd_stall", o_stall, 1'b0);
        chk1("rd_b_cyc", o_b_cyc, 1'b0);
        tick();
        i_stb = 1'b0;
        #2;
        chk1("rd_a_stb_once", o_a_stb, 1'b0);
        chk1("rd_a_cyc_hold", o_a_cyc, 1'b1);
        tick();
        i_a_ack  = 1'b1;
        i_a_data = 32'hDEADBEEF;
        #2;
        chk1("rd_ack", o_ack, 1'b1);
        tick();
        i_a_ack = 1'b0;
        drv(1'b1, 19'h40000);
        #2;
        chk1("rd_a_cyc_done", o_a_cyc, 1'b0);
        chk1("rd_b_stb_now", o_b_stb, 1'b1);
        chk1("rd_b_stall", o_stall, 1'b0);
        tick();
        idle();
        drain_chk("rd_drain");

        // Switch stall: three writes to A, then B waits for all three acks
        for (int i = 0; i < 3; i++) begin
            tick();
            drv(1'b1, AW'(i));
            exp_q.push_back(32'h0);
            #2;
            chk1("sw_a_stb", o_a_stb, 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            drv(1'b0, 19'h40000);
            i_a_ack = 1'b1;
            #2;
            chk1("sw_stall", o_stall, 1'b1);
            chk1("sw_b_cyc", o_b_cyc, 1'b0);
            chk1("sw_b_stb", o_b_stb, 1'b0);
        end
        tick();
        i_a_ack = 1'b0;
        exp_q.push_back(32'h12345678);
        #2;
        chk1("sw_b_stb_go", o_b_stb, 1'b1);
        chk1("sw_b_go_stall", o_stall, 1'b0);
        chk1("sw_a_cyc_off", o_a_cyc, 1'b0);
        tick();
        i_stb = 1'b0;
        tick();
        i_b_ack  = 1'b1;
        i_b_data = 32'h12345678;
        #2;
        chk1("sw_b_ack", o_ack, 1'b1);
        tick();
        idle();
        drain_chk("sw_drain");

        // Unmapped strobe: accepted locally, error one cycle later, then aborted
        tick();
        drv(1'b0, 19'h70000);
        #2;
        chk1("um_a_cyc", o_a_cyc, 1'b0);
        chk1("um_b_cyc", o_b_cyc, 1'b0);
        chk1("um_stall", o_stall, 1'b0);
        chk1("um_err_early", o_err, 1'b0);
        tick();
        i_stb = 1'b0;
        #2;
        chk1("um_err", o_err, 1'b1);
        tick();
        drv(1'b0, 19'h00000);
        #2;
        chk1("um_err_once", o_err, 1'b0);
        chk1("um_abort_stall", o_stall, 1'b1);
        chk1("um_abort_a_cyc", o_a_cyc, 1'b0);
        tick();
        idle();
        tick();
        drv(1'b0, 19'h00000);
        exp_q.push_back(32'h00000055);
        #2;
        chk1("um_recover_stb", o_a_stb, 1'b1);
        tick();
        i_stb    = 1'b0;
        i_a_ack  = 1'b1;
        i_a_data = 32'h00000055;
        tick();
        idle();
        drain_chk("um_drain");

        // Full counter: fourth request waits, issues in the cycle of the first ack
        for (int i = 0; i < 3; i++) begin
            tick();
            drv(1'b1, AW'(i));
            exp_q.push_back(32'h0);
            #2;
            chk1("full_issue_stall", o_stall, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            drv(1'b1, 19'h00003);
            #2;
            chk1("full_stall", o_stall, 1'b1);
            chk1("full_a_stb", o_a_stb, 1'b0);
        end
        tick();
        i_a_ack = 1'b1;
        exp_q.push_back(32'h0);
        #2;
        chk1("full_ack_issue_stb", o_a_stb, 1'b1);
        chk1("full_ack_issue_stall", o_stall, 1'b0);
        chk1("full_ack", o_ack, 1'b1);
        tick();
        i_stb = 1'b0;
        tick();
        tick();
        tick();
        i_a_ack = 1'b0;
        #2;
        chk1("full_a_cyc_done", o_a_cyc, 1'b0);
        tick();
        idle();
        drain_chk("full_drain");

        // Abandon: drop i_cyc with two pending, late ack must be swallowed
        tick();
        drv(1'b0, 19'h00000);
        tick();
        drv(1'b0, 19'h00001);
        tick();
        idle();
        #2;
        chk1("ab_a_cyc", o_a_cyc, 1'b0);
        tick();
        drv(1'b0, 19'h40000);
        i_a_ack = 1'b1;
        exp_q.push_back(32'hCAFE0001);
        #2;
        chk1("ab_late_ack", o_ack, 1'b0);
        chk1("ab_b_stb", o_b_stb, 1'b1);
        tick();
        i_stb   = 1'b0;
        i_a_ack = 1'b0;
        tick();
        i_b_ack  = 1'b1;
        i_b_data = 32'hCAFE0001;
        #2;
        chk1("ab_b_ack", o_ack, 1'b1);
        tick();
        idle();
        drain_chk("ab_drain");

        // Reset mid-operation discards two pending reads
        tick();
        drv(1'b0, 19'h00000);
        tick();
        drv(1'b0, 19'h00001);
        tick();
        i_rst   = 1'b1;
        i_a_ack = 1'b1;
        #2;
        chk1("mr_a_cyc", o_a_cyc, 1'b0);
        chk1("mr_a_stb", o_a_stb, 1'b0);
        chk1("mr_b_cyc", o_b_cyc, 1'b0);
        chk1("mr_stall", o_stall, 1'b1);
        chk1("mr_ack", o_ack, 1'b0);
        chk1("mr_err", o_err, 1'b0);
        tick();
        i_rst = 1'b0;
        i_stb = 1'b0;
        #2;
        chk1("mr_late_ack", o_ack, 1'b0);
        tick();
        i_a_ack = 1'b0;
        drv(1'b0, 19'h00004);
        exp_q.push_back(32'hA5A5A5A5);
        #2;
        chk1("mr_new_stb", o_a_stb, 1'b1);
        tick();
        i_stb = 1'b0;
        tick();
        i_a_ack  = 1'b1;
        i_a_data = 32'hA5A5A5A5;
        tick();
        i_a_ack = 1'b0;
        #2;
        chk1("mr_a_cyc_done", o_a_cyc, 1'b0);
        tick();
        idle();
        drain_chk("mr_drain");

        // Slave error aborts the cycle
        tick();
        drv(1'b0, 19'h00008);
        #2;
        chk1("se_a_stb", o_a_stb, 1'b1);
        tick();
        i_stb   = 1'b0;
        i_a_err = 1'b1;
        #2;
        chk1("se_err", o_err, 1'b1);
        chk1("se_ack", o_ack, 1'b0);
        tick();
        i_a_err = 1'b0;
        i_stb   = 1'b1;
        #2;
        chk1("se_abort_stall", o_stall, 1'b1);
        chk1("se_abort_a_cyc", o_a_cyc, 1'b0);
        chk1("se_err_once", o_err, 1'b0);
        tick();
        idle();
        tick();
        drain_chk("final_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
